control_unit: RTL and testbench

Hardwired control sequencer for the datapath (`main1`). It fetches, decodes and executes one instruction at a time by stepping through states T0–T7 and driving every datapath control strobe, replacing the hand-written per-instruction stimulus. Each state lasts exactly one `clk` period. The opcode is taken from `IR[31:27]`.

---
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer (RST, T0-T7, HALT) driving the datapath strobes.
// Optional macro CU_MEM_WAIT_EN adds mem_ready and stretches T1, ld-T6 and st-T7 until it is high.
module control_unit (
    input  logic        clk,
    input  logic        reset,
`ifdef CU_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    input  logic [31:0] IR,
    output logic        Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl,
    output logic        PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
    output logic        Yin, Zin, ZLowout, ZHighout, Cout,
    output logic        HIin, HIout, LOin, LOout,
    output logic        InPortout, outPortin,
    output logic        conIn, conOut,
    output logic [3:0]  ALUselect,
    output logic        run
);

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011, OP_ANDI = 5'b01100, OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000, OP_HALT = 5'b11011;

    state_t     state, next_state, last_state;
    logic [4:0] op;
    logic       mem_hold, mem_ok;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_RST;
        else        state <= next_state;
    end

    // Final execute state per opcode; ST_T2 means no execute phase at all.
    always_comb begin
        last_state = ST_T2;
        case (op)
            OP_LD, OP_ST:                           last_state = ST_T7;
            OP_BR:                                  last_state = ST_T6;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:       last_state = ST_T5;
            OP_JAL:                                 last_state = ST_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
            OP_HALT:                                last_state = ST_T3;
            default:                                last_state = ST_T2;
        endcase
    end

    assign mem_hold = (state == ST_T1) ||
                      (state == ST_T6 && op == OP_LD) ||
                      (state == ST_T7 && op == OP_ST);

    always_comb begin
        next_state = state;
        case (state)
            ST_RST:  next_state = ST_T0;
            ST_T0:   next_state = ST_T1;
            ST_T1:   next_state = ST_T2;
            ST_HALT: next_state = ST_HALT;
            default: begin
                if (state == last_state)
                    next_state = (op == OP_HALT && state == ST_T3) ? ST_HALT : ST_T0;
                else
                    next_state = state_t'(state + 4'd1);
            end
        endcase
        if (mem_hold && !mem_ok) next_state = state;
    end

    always_comb begin
        {Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl}                        = '0;
        {PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write}     = '0;
        {Yin, Zin, ZLowout, ZHighout, Cout}                               = '0;
        {HIin, HIout, LOin, LOout, InPortout, outPortin, conIn, conOut}   = '0;
        ALUselect = 4'b0000;
        run       = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; ALUselect = 4'b1001; end
            ST_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST:       begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL:  begin R15ctrl = 1'b1; PCout = 1'b1; end
                    OP_IN:   begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin Cout = 1'b1; Zin = 1'b1; ALUselect = 4'b0001; end
                    OP_ANDI: begin Cout = 1'b1; Zin = 1'b1; ALUselect = 4'b0110; end
                    OP_ORI:  begin Cout = 1'b1; Zin = 1'b1; ALUselect = 4'b0111; end
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op)
                    OP_LD, OP_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
                    OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_BR:   begin Cout = 1'b1; Zin = 1'b1; ALUselect = 4'b0001; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op)
                    OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST:   begin MDRin = 1'b1; Gra = 1'b1; Rout = 1'b1; end
                    OP_BR:   begin ZLowout = 1'b1; conOut = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   begin MDRout = 1'b1; Write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle expected strobe words for each instruction,
// plus hand-written halt, reset-abort and (with CU_MEM_WAIT_EN) memory-stall sequences.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] IR = '0;
    logic Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl;
    logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
    logic Yin, Zin, ZLowout, ZHighout, Cout;
    logic HIin, HIout, LOin, LOout, InPortout, outPortin, conIn, conOut;
    logic [3:0] ALUselect;
    logic run;

    control_unit dut (
        .clk(clk), .reset(reset),
`ifdef CU_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .IR(IR),
        .Rin(Rin), .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .R15ctrl(R15ctrl),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write),
        .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout), .Cout(Cout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .InPortout(InPortout), .outPortin(outPortin), .conIn(conIn), .conOut(conOut),
        .ALUselect(ALUselect), .run(run)
    );

    always #5 clk = ~clk;

    logic [33:0] actual;
    assign actual = {Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl,
                     PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
                     Yin, Zin, ZLowout, ZHighout, Cout,
                     HIin, HIout, LOin, LOout, InPortout, outPortin, conIn, conOut,
                     ALUselect, run};

    localparam logic [33:0] RUN = 34'h1;
    localparam logic [33:0] A1 = 34'h2, A6 = 34'hC, A7 = 34'hE, A9 = 34'h12;
    localparam logic [33:0] CONOUT = 34'h1 << 5,  CONIN = 34'h1 << 6,  OUTPORTIN = 34'h1 << 7;
    localparam logic [33:0] INPORTOUT = 34'h1 << 8, LOOUT = 34'h1 << 9, HIOUT = 34'h1 << 11;
    localparam logic [33:0] COUT = 34'h1 << 13, ZLOWOUT = 34'h1 << 15, ZIN = 34'h1 << 16;
    localparam logic [33:0] YIN = 34'h1 << 17, WRITE = 34'h1 << 18, READ = 34'h1 << 19;
    localparam logic [33:0] MDROUT = 34'h1 << 20, MDRIN = 34'h1 << 21, MARIN = 34'h1 << 22;
    localparam logic [33:0] IRIN = 34'h1 << 23, INCPC = 34'h1 << 24, PCOUT = 34'h1 << 25;
    localparam logic [33:0] PCIN = 34'h1 << 26, R15CTRL = 34'h1 << 27, BAOUT = 34'h1 << 28;
    localparam logic [33:0] GRB = 34'h1 << 30, GRA = 34'h1 << 31;
    localparam logic [33:0] ROUT = 34'h1 << 32, RIN = 34'h1 << 33;

    localparam logic [33:0] F0 = PCOUT | MARIN | INCPC | ZIN | A9 | RUN;
    localparam logic [33:0] F1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
    localparam logic [33:0] F2 = MDROUT | IRIN | RUN;

    typedef struct {
        logic [31:0] ir;
        logic [33:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] cur_ir;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [33:0] exp);
        checks++;
        if (actual !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] ir);
        cur_ir = ir;
        vecs.push_back('{ir, F0});
        vecs.push_back('{ir, F1});
        vecs.push_back('{ir, F2});
    endtask

    task automatic ex(input logic [33:0] e);
        vecs.push_back('{cur_ir, e | RUN});
    endtask

    initial begin
        fetch(32'h00800055);                       // ld
        ex(GRB | BAOUT | YIN); ex(COUT | ZIN | A1); ex(ZLOWOUT | MARIN);
        ex(READ | MDRIN); ex(MDROUT | GRA | RIN);
        fetch(32'h1080005A);                       // st
        ex(GRB | BAOUT | YIN); ex(COUT | ZIN | A1); ex(ZLOWOUT | MARIN);
        ex(MDRIN | GRA | ROUT); ex(MDROUT | WRITE);
        fetch(32'h08000000);                       // ldi
        ex(GRB | BAOUT | YIN); ex(COUT | ZIN | A1); ex(ZLOWOUT | GRA | RIN);
        fetch(32'h591FFFFB);                       // addi
        ex(GRB | ROUT | YIN); ex(COUT | ZIN | A1); ex(ZLOWOUT | GRA | RIN);
        fetch(32'h6108001A);                       // andi
        ex(GRB | ROUT | YIN); ex(COUT | ZIN | A6); ex(ZLOWOUT | GRA | RIN);
        fetch(32'h6908001A);                       // ori
        ex(GRB | ROUT | YIN); ex(COUT | ZIN | A7); ex(ZLOWOUT | GRA | RIN);
        fetch(32'h91000023);                       // br
        ex(GRA | ROUT | CONIN); ex(PCOUT | YIN); ex(COUT | ZIN | A1); ex(ZLOWOUT | CONOUT);
        fetch(32'hA0800000);                       // jal
        ex(R15CTRL | PCOUT); ex(GRA | ROUT | PCIN);
        fetch(32'h98000000); ex(GRA | ROUT | PCIN);        // jr
        fetch(32'hA8000000); ex(GRA | RIN | INPORTOUT);    // in
        fetch(32'hB0000000); ex(GRA | ROUT | OUTPORTIN);   // out
        fetch(32'hB8000000); ex(HIOUT | GRA | RIN);        // mfhi
        fetch(32'hC0000000); ex(LOOUT | GRA | RIN);        // mflo
        fetch(32'hD0000000);                               // nop
        fetch(32'hF8000000);                               // unlisted opcode
        fetch(32'hD8000000); ex('0);                       // halt

        repeat (2) @(negedge clk);
        check("reset_state", '0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 IR = vecs[i].ir;
            @(negedge clk);
            check($sformatf("vec%0d_ir%h", i, vecs[i].ir), vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("halt_idle%0d", i), '0);
        end

        reset = 1'b0;
        @(negedge clk);
        check("halt_reset_rst", '0);
        reset = 1'b1;
        @(negedge clk);
        check("halt_reset_t0", F0);

        IR = 32'h00800055;
        @(negedge clk); check("abort_t1", F1);
        @(negedge clk); check("abort_t2", F2);
        @(negedge clk); check("abort_t3", GRB | BAOUT | YIN | RUN);
        @(negedge clk); check("abort_t4", COUT | ZIN | A1 | RUN);
        @(negedge clk); check("abort_t5", ZLOWOUT | MARIN | RUN);
        reset = 1'b0;
        @(negedge clk); check("abort_rst", '0);
        reset = 1'b1;
        @(negedge clk); check("abort_t0", F0);

`ifdef CU_MEM_WAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall_t1_%0d", i), F1);
        end
        mem_ready = 1'b1;
        @(negedge clk); check("stall_t2", F2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
